// File: rtl/tnn_temporal_pkg.sv
// Shared constants and types for the temporal (edge-coded) TNN datapath.
package tnn_temporal_pkg;

  localparam int VAL_W = 3;
  localparam int N     = 16;
  localparam int T_WIN = 2**VAL_W - 1;

  typedef logic [VAL_W-1:0] value_t;

  // The all-ones code means "this line never spikes".
  localparam value_t NULL_VAL  = value_t'(2**VAL_W - 1);
  localparam value_t LAST_TICK = value_t'(T_WIN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RECOVER
  } state_e;

  // A line is low at tick t once its (non-null) value has been reached.
  function automatic logic spike_due(input value_t v, input value_t t);
    return (v != NULL_VAL) && (v <= t);
  endfunction

endpackage

// File: rtl/temporal_spike_lane.sv
// One spike line: holds its latched value and a sticky "fallen" flag.
// The comparison is made against the tick of the upcoming cycle so the
// line output can come straight from a flop.
module temporal_spike_lane
  import tnn_temporal_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   advance_i,
  input  logic   clear_i,
  input  value_t value_i,
  input  value_t tick_i,
  output logic   spike_o
);

  value_t value_q, value_d;
  logic   fallen_q, fallen_d;

  // Load a new value on accept, then fall (and stay fallen) once the tick reaches it.
  always_comb begin
    value_d  = value_q;
    fallen_d = fallen_q;
    if (clear_i) begin
      fallen_d = 1'b0;
    end else if (load_i) begin
      value_d  = value_i;
      fallen_d = spike_due(value_i, tick_i);
    end else if (advance_i) begin
      fallen_d = fallen_q | spike_due(value_q, tick_i);
    end
  end

  // Lane state registers; reset releases the line back to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= NULL_VAL;
      fallen_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      fallen_q <= fallen_d;
    end
  end

  assign spike_o = ~fallen_q;

endmodule

// File: rtl/temporal_encoder_16.sv
// Converts a 16-value volley into edge-coded spike lines over one gamma window.
// This level holds only the FSM, tick counter, handshake and gamma pulses;
// per-line state lives in temporal_spike_lane.
module temporal_encoder_16
  import tnn_temporal_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*VAL_W-1:0] in_values,
  output logic [N-1:0]       spike_out,
  output logic [VAL_W-1:0]   tick,
  output logic               gamma_start,
  output logic               gamma_done
);

  state_e state_q, state_d;
  value_t tick_q, tick_d;
  logic   start_q, start_d;
  logic   done_q, done_d;
  logic   ready_q, ready_d;
  logic   load, advance, clear;

  // Next-state logic; tick_d is the tick of the coming cycle and is shared with the lanes.
  always_comb begin
    state_d = state_q;
    tick_d  = '0;
    start_d = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          state_d = RUN;
          load    = 1'b1;
          start_d = 1'b1;
        end
      end
      RUN: begin
        if (tick_q == LAST_TICK) begin
          state_d = RECOVER;
          clear   = 1'b1;
          done_d  = 1'b1;
        end else begin
          tick_d  = tick_q + value_t'(1);
          advance = 1'b1;
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // Control registers; every output is taken from one of these flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      start_q <= start_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    temporal_spike_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load),
      .advance_i (advance),
      .clear_i   (clear),
      .value_i   (in_values[i*VAL_W +: VAL_W]),
      .tick_i    (tick_d),
      .spike_o   (spike_out[i])
    );
  end

  assign in_ready    = ready_q;
  assign tick        = tick_q;
  assign gamma_start = start_q;
  assign gamma_done  = done_q;

endmodule
